// File: rtl/bitslice_mul_seq.sv
// bitslice_mul_seq: LANES independent unsigned W x W multipliers in bit-plane layout.
// One multiplier plane is consumed per RUN cycle; all lanes advance together.
module bitslice_mul_seq #(
  parameter int W     = 2,
  parameter int LANES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W*LANES-1:0]     a_planes,
  input  logic [W*LANES-1:0]     b_planes,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*W*LANES-1:0]   y_planes
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int AW = 2 * W * LANES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_stateNext;
  logic [W*LANES-1:0]      r_a;
  logic [W*LANES-1:0]      r_b;
  logic [AW-1:0]           r_acc;
  logic [AW-1:0]           r_y;
  logic [CW-1:0]           r_cnt;
  logic [AW-1:0]           w_accNext;
  logic                    w_capture;
  logic                    w_lastStep;
  logic [W-1:0][LANES-1:0] w_pp;
  logic [W-1:0][LANES-1:0] w_top;
  logic [W:0][LANES-1:0]   w_carry;
  logic [W:0][LANES-1:0]   w_sum;

  assign w_capture  = (r_state == IDLE) && in_valid;
  assign w_lastStep = (r_state == RUN) && (r_cnt == CW'(W - 1));
  assign y_planes   = r_y;

  // The partial product is added into the upper W planes of the accumulator,
  // then the whole accumulator shifts down one plane; after W steps it holds a*b.
  always_comb begin
    w_pp    = '0;
    w_top   = '0;
    w_sum   = '0;
    w_carry = '0;
    for (int i = 0; i < W; i++) begin
      w_pp[i]        = r_a[i*LANES +: LANES] & r_b[LANES-1:0];
      w_top[i]       = r_acc[(W+i)*LANES +: LANES];
      w_sum[i]       = w_top[i] ^ w_pp[i] ^ w_carry[i];
      w_carry[i+1]   = (w_top[i] & w_pp[i]) | (w_top[i] & w_carry[i]) | (w_pp[i] & w_carry[i]);
    end
    w_sum[W] = w_carry[W];
  end

  assign w_accNext = AW'({w_sum, r_acc[W*LANES-1:0]} >> LANES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_stateNext = RUN;
      end
      RUN: begin
        if (w_lastStep) w_stateNext = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // The multiplier copy shifts down one plane per step so plane 0 is always the live bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_y   <= '0;
    end else if (w_capture) begin
      r_a   <= a_planes;
      r_b   <= b_planes;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_acc <= w_accNext;
      r_b   <= r_b >> LANES;
      r_cnt <= r_cnt + CW'(1);
      if (w_lastStep) r_y <= w_accNext;
    end
  end

endmodule

// File: tb/tb_bitslice_mul_seq.sv
// tb_bitslice_mul_seq: three configurations (W=2/16 lanes, W=8/4 lanes, W=4/8 lanes)
// checked against a plain a*b model, fixed vectors and handshake corner sequences.
module tb_bitslice_mul_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic iv0, ir0, ov0, or0;
  logic [31:0] a0, b0;
  logic [63:0] y0;
  logic iv1, ir1, ov1, or1;
  logic [31:0] a1, b1;
  logic [63:0] y1;
  logic iv2, ir2, ov2, or2;
  logic [31:0] a2, b2;
  logic [63:0] y2;

  bitslice_mul_seq #(.W(2), .LANES(16)) u_w2 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a_planes(a0), .b_planes(b0),
    .out_valid(ov0), .out_ready(or0), .y_planes(y0));
  bitslice_mul_seq #(.W(8), .LANES(4)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a_planes(a1), .b_planes(b1),
    .out_valid(ov1), .out_ready(or1), .y_planes(y1));
  bitslice_mul_seq #(.W(4), .LANES(8)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a_planes(a2), .b_planes(b2),
    .out_valid(ov2), .out_ready(or2), .y_planes(y2));

  typedef struct {
    logic [31:0] aLanes;
    logic [31:0] bLanes;
    logic [63:0] yLanes;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cfgW[3] = '{2, 8, 4};
  int cfgL[3] = '{16, 4, 8};
  int stimA[64];
  int stimB[64];
  int expY[64];
  logic [31:0] packA, packB;
  logic [63:0] lastY;
  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic buildPlanes(input int w, input int lanes);
    packA = '0;
    packB = '0;
    for (int j = 0; j < lanes; j++)
      for (int i = 0; i < w; i++) begin
        packA[i*lanes+j] = stimA[j][i];
        packB[i*lanes+j] = stimB[j][i];
      end
  endtask

  task automatic modelExpect(input int lanes);
    for (int j = 0; j < lanes; j++) expY[j] = stimA[j] * stimB[j];
  endtask

  function automatic int laneProduct(input logic [63:0] y, input int w, input int lanes, input int j);
    int r = 0;
    for (int k = 0; k < 2*w; k++) if (y[k*lanes+j]) r += (1 << k);
    return r;
  endfunction

  function automatic logic getInReady(input int sel);
    case (sel)
      0: return ir0;
      1: return ir1;
      default: return ir2;
    endcase
  endfunction

  function automatic logic getOutValid(input int sel);
    case (sel)
      0: return ov0;
      1: return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic [63:0] getY(input int sel);
    case (sel)
      0: return y0;
      1: return y1;
      default: return y2;
    endcase
  endfunction

  task automatic applyStimulus(input int sel, input logic v, input logic [31:0] a,
                               input logic [31:0] b, input logic ordy);
    case (sel)
      0: begin iv0 = v; a0 = a; b0 = b; or0 = ordy; end
      1: begin iv1 = v; a1 = a; b1 = b; or1 = ordy; end
      default: begin iv2 = v; a2 = a; b2 = b; or2 = ordy; end
    endcase
  endtask

  // One full transaction: capture, latency count, lane check, optional stall, transfer.
  task automatic runOp(input int sel, input bit scramble, input int hold, input string tag);
    int w, lanes, n;
    w = cfgW[sel];
    lanes = cfgL[sel];
    buildPlanes(w, lanes);
    @(negedge clk);
    n = 0;
    while (!getInReady(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " ready"}, 64'(getInReady(sel)), 64'd1);
    applyStimulus(sel, 1'b1, packA, packB, 1'b0);
    @(negedge clk);
    applyStimulus(sel, 1'b0, scramble ? $urandom : packA, scramble ? $urandom : packB, 1'b0);
    n = 0;
    while (!getOutValid(sel) && n < 40) begin
      @(negedge clk);
      n++;
      if (scramble) applyStimulus(sel, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);
    end
    applyStimulus(sel, 1'b0, packA, packB, 1'b0);
    checkOutput({tag, " latency"}, 64'(n), 64'(w));
    checkOutput({tag, " in_ready busy"}, 64'(getInReady(sel)), 64'd0);
    lastY = getY(sel);
    for (int j = 0; j < lanes; j++)
      checkOutput($sformatf("%s lane%0d", tag, j), 64'(laneProduct(lastY, w, lanes, j)), 64'(expY[j]));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput($sformatf("%s hold%0d out_valid", tag, h), 64'(getOutValid(sel)), 64'd1);
      checkOutput($sformatf("%s hold%0d in_ready", tag, h), 64'(getInReady(sel)), 64'd0);
      checkOutput($sformatf("%s hold%0d y", tag, h), getY(sel), lastY);
    end
    applyStimulus(sel, 1'b0, packA, packB, 1'b1);
    @(negedge clk);
    checkOutput({tag, " after xfer out_valid"}, 64'(getOutValid(sel)), 64'd0);
    checkOutput({tag, " after xfer in_ready"}, 64'(getInReady(sel)), 64'd1);
    applyStimulus(sel, 1'b0, packA, packB, 1'b0);
  endtask

  initial begin
    int setA[3] = '{0, 2, 3};
    int setB[3] = '{3, 2, 1};
    int s, r, n, lastN, w;
    logic saw;

    vecs[0] = '{32'h00000000, 32'hFFFFFFFF, 64'h0000000000000000};
    vecs[1] = '{32'h87654321, 32'h11111111, 64'h0807060504030201};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hE1E1E1E1E1E1E1E1};
    vecs[3] = '{32'h0000000F, 32'h2222222F, 64'h00000000000000E1};
    vecs[4] = '{32'hA5A5A5A5, 32'h3C3C3C3C, 64'h1E3C1E3C1E3C1E3C};
    vecs[5] = '{32'h23456789, 32'h98765432, 64'h12181C1E1E1C1812};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) applyStimulus(k, 1'b0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("reset%0d in_ready", k), 64'(getInReady(k)), 64'd1);
      checkOutput($sformatf("reset%0d out_valid", k), 64'(getOutValid(k)), 64'd0);
      checkOutput($sformatf("reset%0d y", k), getY(k), 64'd0);
    end
    rst = 1'b0;

    for (int j = 0; j < 16; j++) begin
      stimA[j] = j >> 2;
      stimB[j] = j & 3;
    end
    modelExpect(16);
    runOp(0, 1'b0, 0, "exh2x2");
    checkOutput("exh2x2 lane15 const", 64'(laneProduct(lastY, 2, 16, 15)), 64'd9);
    checkOutput("exh2x2 lane6 const", 64'(laneProduct(lastY, 2, 16, 6)), 64'd2);

    for (int j = 0; j < 4; j++) begin
      stimA[j] = 255;
      stimB[j] = 255;
    end
    modelExpect(4);
    runOp(1, 1'b0, 0, "max8");
    for (int j = 0; j < 4; j++)
      checkOutput($sformatf("max8 lane%0d const", j), 64'(laneProduct(lastY, 8, 4, j)), 64'd65025);

    for (int j = 0; j < 16; j++) begin
      stimA[j] = int'($urandom_range(0, 3));
      stimB[j] = int'($urandom_range(0, 3));
    end
    modelExpect(16);
    runOp(0, 1'b0, 5, "backpressure");

    for (int v = 0; v < 6; v++) begin
      for (int j = 0; j < 8; j++) begin
        stimA[j] = int'(vecs[v].aLanes[4*j +: 4]);
        stimB[j] = int'(vecs[v].bLanes[4*j +: 4]);
        expY[j]  = int'(vecs[v].yLanes[8*j +: 8]);
      end
      runOp(2, 1'b0, 0, $sformatf("vec%0d", v));
    end

    // Reset two edges into RUN must drop the transaction silently.
    for (int j = 0; j < 8; j++) begin
      stimA[j] = int'($urandom_range(1, 15));
      stimB[j] = int'($urandom_range(1, 15));
    end
    buildPlanes(4, 8);
    @(negedge clk);
    applyStimulus(2, 1'b1, packA, packB, 1'b0);
    @(negedge clk);
    applyStimulus(2, 1'b0, packA, packB, 1'b0);
    checkOutput("rstrun busy", 64'(ir2), 64'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstrun in_ready", 64'(ir2), 64'd1);
    checkOutput("rstrun out_valid", 64'(ov2), 64'd0);
    checkOutput("rstrun y", y2, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (ov2) saw = 1'b1;
    end
    checkOutput("rstrun no out_valid", 64'(saw), 64'd0);
    modelExpect(8);
    runOp(2, 1'b0, 0, "after rst");

    // Back-to-back with in_valid held high: results every W+2 cycles.
    s = 0; r = 0; n = 0; lastN = -1;
    @(negedge clk);
    or0 = 1'b1;
    while (r < 3 && n < 60) begin
      if (ov0) begin
        for (int j = 0; j < 16; j++)
          checkOutput($sformatf("b2b res%0d lane%0d", r, j), 64'(laneProduct(y0, 2, 16, j)),
                      64'(setA[r] * setB[r]));
        if (r > 0) checkOutput($sformatf("b2b spacing%0d", r), 64'(n - lastN), 64'd4);
        lastN = n;
        r++;
      end
      if (ir0) begin
        if (s < 3) begin
          for (int j = 0; j < 16; j++) begin
            stimA[j] = setA[s];
            stimB[j] = setB[s];
          end
          buildPlanes(2, 16);
          applyStimulus(0, 1'b1, packA, packB, 1'b1);
          s++;
        end else begin
          applyStimulus(0, 1'b0, packA, packB, 1'b1);
        end
      end
      @(negedge clk);
      n++;
    end
    checkOutput("b2b count", 64'(r), 64'd3);
    applyStimulus(0, 1'b0, packA, packB, 1'b0);

    for (int j = 0; j < 8; j++) begin
      stimA[j] = int'($urandom_range(0, 15));
      stimB[j] = int'($urandom_range(0, 15));
    end
    modelExpect(8);
    runOp(2, 1'b1, 0, "scramble4");
    for (int j = 0; j < 4; j++) begin
      stimA[j] = int'($urandom_range(0, 255));
      stimB[j] = int'($urandom_range(0, 255));
    end
    modelExpect(4);
    runOp(1, 1'b1, 0, "scramble8");

    for (int t = 0; t < 9; t++) begin
      w = cfgW[t % 3];
      for (int j = 0; j < cfgL[t % 3]; j++) begin
        stimA[j] = int'($urandom_range(0, (1 << w) - 1));
        stimB[j] = int'($urandom_range(0, (1 << w) - 1));
      end
      modelExpect(cfgL[t % 3]);
      runOp(t % 3, 1'b0, t % 2, $sformatf("rand%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
